data_mem_pipe: RTL and testbench

- Parametrised successor to the CPU's single-cycle data memory.
- Adds a valid/ready request interface, byte-lane write enables, and a configurable registered read latency (1 or 2).
- Clears all memory to zero after reset using a hardware init sequencer.
- Flags out-of-range accesses.
- Sits between the MEM stage and the datapath. `rsp_rdata` feeds the write-back mux.

---
 rtl/data_mem_pipe.sv | 194 +++++++++++++++++++
 tb/tb_data_mem_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_pipe.sv
// data_mem_pipe: pipelined data memory for the MEM stage.
// Valid/ready request port, byte-lane write enables, registered read
// latency of 1 or 2 cycles, hardware clear sequencer after reset and
// out-of-range flagging.
// Optional build macro DMEM_PARITY_EN: per-byte even parity with error
// injection (inj_par_err) and a sticky parity error flag (par_err_sticky).
module data_mem_pipe #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 16,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
`ifdef DMEM_PARITY_EN
  input  logic                inj_par_err,
  output logic                par_err_sticky,
`endif
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Elaboration-time parameter legality checks
  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
    $fatal(1, "data_mem_pipe: DATA_W must be a non-zero multiple of 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "data_mem_pipe: DEPTH must be a power of two >= 2");
  end
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $fatal(1, "data_mem_pipe: READ_LAT must be 1 or 2");
  end

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               accept;
  logic               rd_acc;
  logic               in_range;
  logic [ADDR_W-1:0]  addr_hi;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  rd_word;
  logic               par_bad;

  logic               s1_valid;
  logic [DATA_W-1:0]  s1_data;
  logic               s1_err;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  // Next state: leave INIT on the edge that clears the last word
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    init_done = 1'b0;
    case (state)
      S_INIT: if (clr_cnt == '1) state_nxt = S_RUN;
      S_RUN: begin
        req_ready = 1'b1;
        init_done = 1'b1;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Clear-sequence word counter
  always_ff @(posedge clk) begin
    if (rst)                 clr_cnt <= '0;
    else if (state == S_INIT) clr_cnt <= clr_cnt + 1'b1;
  end

  // Request decode: any set bit above the index field is out of range
  always_comb begin
    accept   = req_valid && req_ready;
    rd_acc   = accept && !req_we;
    addr_hi  = req_addr >> IDX_W;
    in_range = (addr_hi == '0);
    idx      = req_addr[IDX_W-1:0];
    rd_word  = mem[idx];
  end

  // Memory array: clear during INIT, byte-lane writes during RUN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) begin
        mem[clr_cnt] <= '0;
      end else if (accept && req_we && in_range) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] lane_bad;

  // Parity store: zero data has zero parity; injection inverts written lanes
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT) begin
        par_mem[clr_cnt] <= '0;
      end else if (accept && req_we && in_range) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (req_be[i]) par_mem[idx][i] <= (^req_wdata[8*i +: 8]) ^ inj_par_err;
        end
      end
    end
  end

  // Per-lane parity check of the addressed word
  always_comb begin
    lane_bad = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      lane_bad[i] = par_mem[idx][i] ^ (^rd_word[8*i +: 8]);
    end
    par_bad = in_range && (lane_bad != '0);
  end

  // Sticky parity error, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)                    par_err_sticky <= 1'b0;
    else if (rd_acc && par_bad) par_err_sticky <= 1'b1;
  end
`else
  always_comb par_bad = 1'b0;
`endif

  // First read stage: sample memory at the accept edge
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= rd_acc;
      s1_data  <= (rd_acc && in_range) ? rd_word : '0;
      s1_err   <= rd_acc && (!in_range || par_bad);
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    logic              s2_err;

    // Second read stage, flushed by reset
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
        s2_err   <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        s2_data  <= s1_data;
        s2_err   <= s1_err;
      end
    end

    // Response from the second stage
    always_comb begin
      rsp_valid = s2_valid;
      rsp_rdata = s2_data;
      rsp_err   = s2_err;
    end
  end else begin : g_lat1
    // Response straight from the first stage
    always_comb begin
      rsp_valid = s1_valid;
      rsp_rdata = s1_data;
      rsp_err   = s1_err;
    end
  end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Self-checking bench for data_mem_pipe: one instance at READ_LAT=1 and one
// at READ_LAT=2 share stimulus; a transaction-level model predicts both.
module tb_data_mem_pipe;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = '0;
  logic        inj_par_err = 1'b0;

  logic        d1_ready, d1_valid, d1_err, d1_init;
  logic [15:0] d1_rdata;
  logic        d2_ready, d2_valid, d2_err, d2_init;
  logic [15:0] d2_rdata;
`ifdef DMEM_PARITY_EN
  logic        d1_sticky, d2_sticky;
`endif

  always #5 clk = ~clk;

  data_mem_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .READ_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d1_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
`ifdef DMEM_PARITY_EN
    .inj_par_err(inj_par_err), .par_err_sticky(d1_sticky),
`endif
    .rsp_valid(d1_valid), .rsp_rdata(d1_rdata), .rsp_err(d1_err), .init_done(d1_init)
  );

  data_mem_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .READ_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(d2_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
`ifdef DMEM_PARITY_EN
    .inj_par_err(inj_par_err), .par_err_sticky(d2_sticky),
`endif
    .rsp_valid(d2_valid), .rsp_rdata(d2_rdata), .rsp_err(d2_err), .init_done(d2_init)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  typedef struct { int due; logic [15:0] data; logic err; } rsp_t;
  rsp_t        q1[$];
  rsp_t        q2[$];
  logic [15:0] m_mem [DEPTH];
  logic [1:0]  m_bad [DEPTH];
  bit          m_run = 0;
  int          m_icnt = 0;
  bit          m_sticky = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit          inr;
    int          a;
    logic [15:0] d;
    logic        e;
    if (rst) begin
      m_run = 0; m_icnt = 0; m_sticky = 0;
      q1.delete(); q2.delete();
    end else if (!m_run) begin
      m_icnt++;
      if (m_icnt == DEPTH) begin
        m_run = 1;
        for (int k = 0; k < DEPTH; k++) begin m_mem[k] = '0; m_bad[k] = '0; end
      end
    end else if (req_valid) begin
      inr = (int'(req_addr) < DEPTH);
      a   = int'(req_addr) % DEPTH;
      if (req_we) begin
        if (inr) begin
          for (int l = 0; l < 2; l++) begin
            if (req_be[l]) begin
              m_mem[a][8*l +: 8] = req_wdata[8*l +: 8];
              m_bad[a][l] = inj_par_err;
            end
          end
        end
      end else begin
        d = inr ? m_mem[a] : 16'h0000;
        e = !inr;
`ifdef DMEM_PARITY_EN
        if (inr && m_bad[a] != 2'b00) begin e = 1'b1; m_sticky = 1; end
`endif
        q1.push_back('{cyc + 1, d, e});
        q2.push_back('{cyc + 2, d, e});
      end
    end
  endtask

  // One clock: advance model on current inputs, then compare both DUTs
  task automatic tick();
    bit          ev;
    logic [15:0] ed;
    logic        ee;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    ev = 0; ed = '0; ee = 0;
    if (q1.size() != 0 && q1[0].due == cyc) begin
      ev = 1; ed = q1[0].data; ee = q1[0].err; void'(q1.pop_front());
    end
    chk("lat1_valid", d1_valid, ev);
    chk("lat1_rdata", d1_rdata, ed);
    if (ev) chk("lat1_err", d1_err, ee);
    ev = 0; ed = '0; ee = 0;
    if (q2.size() != 0 && q2[0].due == cyc) begin
      ev = 1; ed = q2[0].data; ee = q2[0].err; void'(q2.pop_front());
    end
    chk("lat2_valid", d2_valid, ev);
    chk("lat2_rdata", d2_rdata, ed);
    if (ev) chk("lat2_err", d2_err, ee);
    chk("lat1_ready", d1_ready, m_run);
    chk("lat2_ready", d2_ready, m_run);
    chk("lat1_init_done", d1_init, m_run);
    chk("lat2_init_done", d2_init, m_run);
`ifdef DMEM_PARITY_EN
    chk("lat1_sticky", d1_sticky, m_sticky);
    chk("lat2_sticky", d2_sticky, m_sticky);
`endif
  endtask

  task automatic op(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                    input logic [1:0] be);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!(d1_init && d2_init) && n < 40) begin tick(); n++; end
    chk("init_wait", {d1_init, d2_init}, 2'b11);
  endtask

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_d;
    bit          exp_e;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  initial begin
    int n;
    tbl = '{
      '{1'b1, 16'h0003, 16'hABCD, 2'b11, 16'h0000, 1'b0},
      '{1'b0, 16'h0003, 16'h0000, 2'b00, 16'hABCD, 1'b0},
      '{1'b1, 16'h0003, 16'h1234, 2'b01, 16'h0000, 1'b0},
      '{1'b0, 16'h0003, 16'h0000, 2'b00, 16'hAB34, 1'b0},
      '{1'b1, 16'h0003, 16'h5678, 2'b00, 16'h0000, 1'b0},
      '{1'b0, 16'h0003, 16'h0000, 2'b00, 16'hAB34, 1'b0},
      '{1'b1, 16'h0010, 16'hFFFF, 2'b11, 16'h0000, 1'b0},
      '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'h0000, 1'b1},
      '{1'b0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 1'b0},
      '{1'b1, 16'h0003, 16'h9900, 2'b10, 16'h0000, 1'b0},
      '{1'b0, 16'h0003, 16'h0000, 2'b00, 16'h9934, 1'b0},
      '{1'b1, 16'h8003, 16'hFFFF, 2'b11, 16'h0000, 1'b0},
      '{1'b0, 16'h0003, 16'h0000, 2'b00, 16'h9934, 1'b0},
      '{1'b0, 16'hFFFF, 16'h0000, 2'b00, 16'h0000, 1'b1},
      '{1'b1, 16'h0001, 16'h1111, 2'b11, 16'h0000, 1'b0},
      '{1'b1, 16'h0002, 16'h2222, 2'b11, 16'h0000, 1'b0},
      '{1'b0, 16'h0005, 16'h0000, 2'b00, 16'h0000, 1'b0}
    };

    // Clear sequence: 3 reset cycles, then init_done exactly 16 cycles later
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    n = 0;
    while (!d1_init && n < 40) begin tick(); n++; end
    chk("init_latency", n, 16);

    // Every word reads back as zero, back-to-back
    for (int a = 0; a < DEPTH; a++) begin
      op(1'b0, 16'(a), 16'h0000, 2'b00);
      tick();
    end
    idle();
    repeat (3) tick();

    // Directed table: writes issue back-to-back into the following read
    for (int i = 0; i < NV; i++) begin
      op(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be);
      tick();
      if (!tbl[i].we) begin
        chk($sformatf("tbl%0d_lat1_valid", i), d1_valid, 1'b1);
        chk($sformatf("tbl%0d_lat1_data", i), d1_rdata, tbl[i].exp_d);
        chk($sformatf("tbl%0d_lat1_err", i), d1_err, tbl[i].exp_e);
        idle();
        tick();
        chk($sformatf("tbl%0d_lat2_valid", i), d2_valid, 1'b1);
        chk($sformatf("tbl%0d_lat2_data", i), d2_rdata, tbl[i].exp_d);
        chk($sformatf("tbl%0d_lat2_err", i), d2_err, tbl[i].exp_e);
      end
    end
    idle();
    repeat (3) tick();

    // Consecutive reads at READ_LAT=2 arrive at +2 and +3, in order
    op(1'b0, 16'h0001, 16'h0000, 2'b00); tick();
    op(1'b0, 16'h0002, 16'h0000, 2'b00); tick();
    chk("p5_first_valid", d2_valid, 1'b1);
    chk("p5_first_data", d2_rdata, 16'h1111);
    idle(); tick();
    chk("p5_second_valid", d2_valid, 1'b1);
    chk("p5_second_data", d2_rdata, 16'h2222);
    tick();
    chk("p5_after_valid", d2_valid, 1'b0);

    // Reset one cycle after the second read: nothing in flight survives
    op(1'b0, 16'h0001, 16'h0000, 2'b00); tick();
    op(1'b0, 16'h0002, 16'h0000, 2'b00); tick();
    idle();
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("p5_flush_lat1", d1_valid, 1'b0);
      chk("p5_flush_lat2", d2_valid, 1'b0);
      chk("p5_reinit_ready", d2_ready, 1'b0);
    end
    wait_init();

`ifdef DMEM_PARITY_EN
    // Injected parity error: data intact, rsp_err and sticky set
    op(1'b1, 16'h0005, 16'h00FF, 2'b11);
    inj_par_err = 1'b1; tick(); inj_par_err = 1'b0;
    op(1'b0, 16'h0005, 16'h0000, 2'b00); tick();
    chk("par_data", d1_rdata, 16'h00FF);
    chk("par_err", d1_err, 1'b1);
    chk("par_sticky", d1_sticky, 1'b1);
    op(1'b0, 16'h0000, 16'h0000, 2'b00); tick();
    chk("par_clean_err", d1_err, 1'b0);
    idle(); tick();
    chk("par_sticky_hold", d2_sticky, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("par_sticky_clear", d1_sticky, 1'b0);
    wait_init();
`endif

    // Randomized traffic with occasional resets
    for (int k = 0; k < 600; k++) begin
      rst         = ($urandom_range(0, 149) == 0);
      req_valid   = ($urandom_range(0, 3) != 0);
      req_we      = $urandom_range(0, 1);
      req_addr    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
      req_wdata   = 16'($urandom);
      req_be      = 2'($urandom_range(0, 3));
`ifdef DMEM_PARITY_EN
      inj_par_err = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end
    rst = 1'b0;
    inj_par_err = 1'b0;
    idle();
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
